ex_div: RTL and testbench

- Multi-cycle restoring radix-2 integer divider serving the execute stage for DIV/DIVU.
- Execute issues operands and a start request, then holds the pipeline until ready_o.
- It then consumes the 64-bit {remainder, quotient} result and writes it to HI/LO.
- One quotient bit per clock; the block is idle between operations.

---
 rtl/ex_div_if.sv | 23 ++
 rtl/ex_div.sv | 147 ++++++++++++++
 tb/tb_ex_div.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Handshake bundle between the execute stage (master) and the ex_div divider (slave).
// Signal names keep the divider-side direction suffixes so both ends read the same.
interface ex_div_if #(
   parameter int DATA_W = 32
);
   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/ex_div.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock, result {rem, quot}.
// Optional EX_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_div #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic    clk,
   input  logic    rst,
   ex_div_if.slave div_if
);

   typedef enum logic [1:0] {FREE = 2'd0, BYZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W:0]     work_q, work_d;
   logic [DATA_W-1:0]     divisor_q, divisor_d;
   logic                  neg_quot_q, neg_quot_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;

   logic [DATA_W-1:0]     op1_abs, op2_abs;
   logic [DATA_W:0]       trial;
   logic [2*DATA_W:0]     step;

   // Signed mode divides magnitudes; 0x80000000 maps onto itself, which is correct unsigned.
   assign op1_abs = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1]) ?
                    -div_if.opdata1_i : div_if.opdata1_i;
   assign op2_abs = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1]) ?
                    -div_if.opdata2_i : div_if.opdata2_i;

   assign trial = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
   assign step  = trial[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                                : {trial[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};

   function automatic logic [2*DATA_W-1:0] fix_result(input logic [DATA_W-1:0] q,
                                                       input logic [DATA_W-1:0] r,
                                                       input logic nq, input logic nr);
      logic [DATA_W-1:0] qf, rf;
      qf = nq ? -q : q;
      rf = nr ? -r : r;
      return {rf, qf};
   endfunction

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (div_if.start_i && !div_if.annul_i) begin
               work_d     = {{DATA_W{1'b0}}, op1_abs, 1'b0};
               divisor_d  = op2_abs;
               cnt_d      = '0;
               neg_quot_d = div_if.signed_div_i &
                            (div_if.opdata1_i[DATA_W-1] ^ div_if.opdata2_i[DATA_W-1]);
               neg_rem_d  = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
               if (div_if.opdata2_i == '0)
                  state_d = BYZERO;
`ifdef EX_DIV_EARLY_OUT_EN
               else if (op1_abs < op2_abs)
                  state_d = BYZERO;
`endif
               else
                  state_d = ON;
            end
         end
         BYZERO: begin
            if (div_if.annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               state_d  = END;
               ready_d  = 1'b1;
               result_d = '0;
`ifdef EX_DIV_EARLY_OUT_EN
               // A non-zero divisor here means the early-out path: quotient 0, remainder = dividend.
               if (divisor_q != '0)
                  result_d = fix_result('0, work_q[DATA_W:1], neg_quot_q, neg_rem_q);
`endif
            end
         end
         ON: begin
            if (div_if.annul_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               work_d = step;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d  = END;
                  ready_d  = 1'b1;
                  result_d = fix_result(step[DATA_W-1:0], step[2*DATA_W:DATA_W+1],
                                        neg_quot_q, neg_rem_q);
               end
            end
         end
         END: begin
            if (div_if.annul_i || !div_if.start_i) begin
               state_d  = FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: state_d = FREE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FREE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign div_if.result_o = result_q;
   assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: stimulus pushes {result, ready cycle}; a monitor pops on ready rise.
module tb_ex_div;

   localparam int LAT_FULL = 32;
`ifdef EX_DIV_EARLY_OUT_EN
   localparam int LAT_EARLY = 1;
`else
   localparam int LAT_EARLY = 32;
`endif

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   logic ready_prev;
   exp_t sb[$];

   ex_div_if #(.DATA_W(32)) dif();

   ex_div #(.DATA_W(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every rising ready_o must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && dif.ready_o && !ready_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", dif.result_o, e.res);
            check("latency", 64'(cyc), 64'(e.cyc));
         end
      end
      ready_prev <= dif.ready_o;
   end

   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat);
      exp_t e;
      @(negedge clk);
      dif.signed_div_i = sgn;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      dif.start_i      = 1'b1;
      e.res = exp_res;
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      dif.opdata1_i    = ~a;
      dif.opdata2_i    = b ^ 32'h5A5A_0003;
      dif.signed_div_i = ~sgn;
      for (int i = 0; i < lat + 5 && !dif.ready_o; i++) @(negedge clk);
      check("ready_timeout", 64'(dif.ready_o), 64'd1);
      repeat (2) begin
         @(negedge clk);
         check("hold_ready", 64'(dif.ready_o), 64'd1);
         check("hold_result", dif.result_o, exp_res);
      end
      dif.start_i = 1'b0;
      @(negedge clk);
      check("drop_ready", 64'(dif.ready_o), 64'd0);
      check("drop_result", dif.result_o, 64'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      ready_prev       = 1'b0;
      rst              = 1'b0;
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = '0;
      dif.opdata2_i    = '0;
      dif.start_i      = 1'b0;
      dif.annul_i      = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ready", 64'(dif.ready_o), 64'd0);
      check("reset_result", dif.result_o, 64'd0);
      rst = 1'b1;

      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, LAT_FULL);
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, LAT_FULL);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, LAT_FULL);
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, LAT_FULL);
      run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, LAT_FULL);
      run_div(1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, LAT_FULL);
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, LAT_FULL);
      run_div(1'b0, 32'h00001234, 32'd0, 64'd0, 1);
      run_div(1'b1, 32'h80000000, 32'd0, 64'd0, 1);
      run_div(1'b0, 32'd3, 32'd10, 64'h00000003_00000000, LAT_EARLY);
      run_div(1'b1, 32'hFFFFFFFB, 32'd7, 64'hFFFFFFFB_00000000, LAT_EARLY);

      // Annul after ten iterations: the operation must vanish without ever raising ready_o.
      @(negedge clk);
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd100;
      dif.opdata2_i    = 32'd7;
      dif.start_i      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      dif.annul_i = 1'b1;
      dif.start_i = 1'b0;
      @(negedge clk);
      dif.annul_i = 1'b0;
      check("annul_ready", 64'(dif.ready_o), 64'd0);
      check("annul_result", dif.result_o, 64'd0);
      repeat (30) @(negedge clk);
      check("annul_ready_later", 64'(dif.ready_o), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, LAT_FULL);

      // Asynchronous reset between edges while iterating.
      @(negedge clk);
      dif.opdata1_i = 32'h12345678;
      dif.opdata2_i = 32'd5;
      dif.start_i   = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_ready", 64'(dif.ready_o), 64'd0);
      check("async_rst_result", dif.result_o, 64'd0);
      dif.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_ready", 64'(dif.ready_o), 64'd0);
      run_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, LAT_FULL);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
